// File: rtl/processor.sv
// -----------------------------------------------------------------------------
// processor
//
// Instruction fetch front end with a byte-addressed, big-endian local memory.
// The memory is filled by an external S-record loader while srec_parse is
// high. When srec_parse is low and stall is low, each rising edge fetches one
// 32-bit word at pc and advances pc by 4. The decode fields are plain
// combinational slices of the fetched word.
//
// Parameters
//   MEM_BASE   first byte address of memory, also the pc reset value
//   MEM_DEPTH  memory size in bytes (power of two)
//
// Ports
//   clk               in   single clock, rising edge
//   rst_n             in   asynchronous active-low reset
//   srec_parse        in   loader mode: memory written externally, fetch frozen
//   stall             in   hold pc and fetch outputs
//   srec_address      in   loader byte address
//   srec_data_in      in   loader write data, right-aligned
//   srec_access_size  in   00/01 byte, 10 halfword, 11 word
//   srec_rw           in   loader write strobe
//   pc                out  current fetch address
//   insn              out  last fetched instruction word
//   insn_pc           out  address insn was fetched from
//   insn_valid        out  insn holds a fetched word
//   opcode, rs, rt, rd, shamt, funct, imm   out  decode fields of insn
//
// Configuration macro
//   MEM_BOUNDS_CHECK_EN  defined: loader bytes outside
//                        [MEM_BASE, MEM_BASE+MEM_DEPTH) are dropped and
//                        fetched bytes outside that window read as 8'h00.
//                        undefined: addresses wrap modulo MEM_DEPTH.
// -----------------------------------------------------------------------------
module processor #(
  parameter logic [31:0] MEM_BASE  = 32'h8002_0000,
  parameter int          MEM_DEPTH = 1048576
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        srec_parse,
  input  logic        stall,
  input  logic [31:0] srec_address,
  input  logic [31:0] srec_data_in,
  input  logic [1:0]  srec_access_size,
  input  logic        srec_rw,
  output logic [31:0] pc,
  output logic [31:0] insn,
  output logic [31:0] insn_pc,
  output logic        insn_valid,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm
);

  localparam int AW = $clog2(MEM_DEPTH);

`ifdef MEM_BOUNDS_CHECK_EN
  localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);

  // Unsigned subtraction folds both "below base" and "above top" into one
  // compare: anything below MEM_BASE wraps to a huge offset.
  function automatic logic in_range(input logic [31:0] addr);
    return (addr - MEM_BASE) < DEPTH_W;
  endfunction
`endif

  // Offset into memory, reduced modulo MEM_DEPTH.
  function automatic logic [AW-1:0] mem_idx(input logic [31:0] addr);
    return AW'(addr - MEM_BASE);
  endfunction

  logic [7:0]  mem [MEM_DEPTH];

  logic [3:0]  wr_en;
  logic [31:0] wr_addr [4];
  logic [7:0]  wr_byte [4];
  logic [7:0]  rd_byte [4];
  logic [31:0] fetch_word;

  logic [31:0] pc_q, pc_d;
  logic [31:0] insn_q, insn_d;
  logic [31:0] insn_pc_q, insn_pc_d;
  logic        insn_valid_q, insn_valid_d;
  logic        fetch_en;

  // ---------------------------------------------------------------------------
  // Loader write lanes: lane i targets srec_address+i. Data is right-aligned,
  // so the most significant used byte lands at the lowest address.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_en = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      wr_addr[i] = srec_address + 32'(i);
      wr_byte[i] = 8'h00;
    end
    if (srec_parse && srec_rw) begin
      case (srec_access_size)
        2'b10: begin
          wr_en      = 4'b0011;
          wr_byte[0] = srec_data_in[15:8];
          wr_byte[1] = srec_data_in[7:0];
        end
        2'b11: begin
          wr_en      = 4'b1111;
          wr_byte[0] = srec_data_in[31:24];
          wr_byte[1] = srec_data_in[23:16];
          wr_byte[2] = srec_data_in[15:8];
          wr_byte[3] = srec_data_in[7:0];
        end
        default: begin
          wr_en      = 4'b0001;
          wr_byte[0] = srec_data_in[7:0];
        end
      endcase
    end
`ifdef MEM_BOUNDS_CHECK_EN
    for (int i = 0; i < 4; i++) begin
      if (!in_range(wr_addr[i])) begin
        wr_en[i] = 1'b0;
      end
    end
`endif
  end

  // Memory contents survive reset; a write coinciding with reset is dropped
  // so that asserting rst_n aborts an in-flight load cycle.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_en[i]) begin
          mem[mem_idx(wr_addr[i])] <= wr_byte[i];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch read: four consecutive bytes from pc, no alignment requirement.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rd_byte[i] = mem[mem_idx(pc_q + 32'(i))];
`ifdef MEM_BOUNDS_CHECK_EN
      if (!in_range(pc_q + 32'(i))) begin
        rd_byte[i] = 8'h00;
      end
`endif
    end
    fetch_word = {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]};
  end

  // Loader mode has priority over a deasserted stall.
  assign fetch_en = !srec_parse && !stall;

  always_comb begin
    pc_d         = pc_q;
    insn_d       = insn_q;
    insn_pc_d    = insn_pc_q;
    insn_valid_d = insn_valid_q;
    if (fetch_en) begin
      insn_d       = fetch_word;
      insn_pc_d    = pc_q;
      insn_valid_d = 1'b1;
      pc_d         = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= MEM_BASE;
      insn_q       <= 32'h0000_0000;
      insn_pc_q    <= 32'h0000_0000;
      insn_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      insn_q       <= insn_d;
      insn_pc_q    <= insn_pc_d;
      insn_valid_q <= insn_valid_d;
    end
  end

  assign pc         = pc_q;
  assign insn       = insn_q;
  assign insn_pc    = insn_pc_q;
  assign insn_valid = insn_valid_q;

  assign opcode = insn_q[31:26];
  assign rs     = insn_q[25:21];
  assign rt     = insn_q[20:16];
  assign rd     = insn_q[15:11];
  assign shamt  = insn_q[10:6];
  assign funct  = insn_q[5:0];
  assign imm    = insn_q[15:0];

endmodule

// File: tb/tb_processor.sv
module tb_processor;

  localparam logic [31:0] BASE  = 32'h8002_0000;
  localparam int          DEPTH = 256;

  logic        clk;
  logic        rst_n;
  logic        srec_parse;
  logic        stall;
  logic [31:0] srec_address;
  logic [31:0] srec_data_in;
  logic [1:0]  srec_access_size;
  logic        srec_rw;
  logic [31:0] pc;
  logic [31:0] insn;
  logic [31:0] insn_pc;
  logic        insn_valid;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;

  int errors = 0;
  int checks = 0;

  processor #(
    .MEM_BASE (BASE),
    .MEM_DEPTH(DEPTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .srec_parse      (srec_parse),
    .stall           (stall),
    .srec_address    (srec_address),
    .srec_data_in    (srec_data_in),
    .srec_access_size(srec_access_size),
    .srec_rw         (srec_rw),
    .pc              (pc),
    .insn            (insn),
    .insn_pc         (insn_pc),
    .insn_valid      (insn_valid),
    .opcode          (opcode),
    .rs              (rs),
    .rt              (rt),
    .rd              (rd),
    .shamt           (shamt),
    .funct           (funct),
    .imm             (imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        parse;
    logic        rw;
    logic        stl;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_pc;
    logic [31:0] exp_insn;
    logic [31:0] exp_ipc;
    logic        exp_v;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic parse, input logic rw, input logic stl,
                              input logic [1:0] size, input logic [31:0] addr,
                              input logic [31:0] data, input logic [31:0] exp_pc,
                              input logic [31:0] exp_insn, input logic [31:0] exp_ipc,
                              input logic exp_v);
    vec_t v;
    v.parse = parse; v.rw = rw; v.stl = stl; v.size = size;
    v.addr = addr; v.data = data; v.exp_pc = exp_pc;
    v.exp_insn = exp_insn; v.exp_ipc = exp_ipc; v.exp_v = exp_v;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic parse, input logic rw, input logic stl,
                       input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] data);
    srec_parse       = parse;
    srec_rw          = rw;
    stall            = stl;
    srec_access_size = size;
    srec_address     = addr;
    srec_data_in     = data;
  endtask

  // One clock edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_once();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    step();
  endtask

  task automatic run_vec(input int k);
    string tag;
    drive(vecs[k].parse, vecs[k].rw, vecs[k].stl, vecs[k].size, vecs[k].addr, vecs[k].data);
    step();
    tag = $sformatf("v%0d", k);
    check({tag, ".pc"},      pc,      vecs[k].exp_pc);
    check({tag, ".insn"},    insn,    vecs[k].exp_insn);
    check({tag, ".insn_pc"}, insn_pc, vecs[k].exp_ipc);
    check({tag, ".valid"},   {31'b0, insn_valid}, {31'b0, vecs[k].exp_v});
  endtask

  // Reset with loader mode selected and no write so edges around release are idle.
  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  logic [31:0] wrap_exp;

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);

    // parse rw stl size addr data | pc insn insn_pc valid
    vecs[0]  = mk(1, 1, 0, 2'b00, BASE + 32'h00, 32'h0000_0024, BASE, 32'h0, 32'h0, 0);
    vecs[1]  = mk(1, 1, 0, 2'b00, BASE + 32'h01, 32'hFFFF_FF08, BASE, 32'h0, 32'h0, 0);
    vecs[2]  = mk(1, 1, 0, 2'b01, BASE + 32'h02, 32'h0000_0000, BASE, 32'h0, 32'h0, 0);
    vecs[3]  = mk(1, 1, 0, 2'b00, BASE + 32'h03, 32'h0000_0005, BASE, 32'h0, 32'h0, 0);
    vecs[4]  = mk(1, 1, 0, 2'b11, BASE + 32'h04, 32'hDEAD_BEEF, BASE, 32'h0, 32'h0, 0);
    vecs[5]  = mk(1, 1, 0, 2'b11, BASE + 32'h08, 32'h5566_7788, BASE, 32'h0, 32'h0, 0);
    vecs[6]  = mk(1, 1, 0, 2'b10, BASE + 32'h08, 32'hFFFF_1234, BASE, 32'h0, 32'h0, 0);
    vecs[7]  = mk(1, 1, 0, 2'b11, BASE + 32'h0C, 32'h8C0A_0010, BASE, 32'h0, 32'h0, 0);
    vecs[8]  = mk(1, 0, 0, 2'b11, BASE + 32'h00, 32'hFFFF_FFFF, BASE, 32'h0, 32'h0, 0);
    vecs[9]  = mk(0, 0, 0, 2'b00, 32'h0, 32'h0, BASE + 32'h08, 32'hDEAD_BEEF, BASE + 32'h04, 1);
    vecs[10] = mk(0, 0, 1, 2'b00, 32'h0, 32'h0, BASE + 32'h08, 32'hDEAD_BEEF, BASE + 32'h04, 1);
    vecs[11] = mk(0, 0, 1, 2'b00, 32'h0, 32'h0, BASE + 32'h08, 32'hDEAD_BEEF, BASE + 32'h04, 1);
    vecs[12] = mk(0, 0, 1, 2'b00, 32'h0, 32'h0, BASE + 32'h08, 32'hDEAD_BEEF, BASE + 32'h04, 1);
    vecs[13] = mk(0, 0, 0, 2'b00, 32'h0, 32'h0, BASE + 32'h0C, 32'h1234_7788, BASE + 32'h08, 1);
    vecs[14] = mk(1, 0, 0, 2'b00, 32'h0, 32'h0, BASE + 32'h0C, 32'h1234_7788, BASE + 32'h08, 1);
    vecs[15] = mk(0, 0, 0, 2'b00, 32'h0, 32'h0, BASE + 32'h10, 32'h8C0A_0010, BASE + 32'h0C, 1);

    do_reset();
    check("rst.pc",      pc,      BASE);
    check("rst.insn",    insn,    32'h0);
    check("rst.insn_pc", insn_pc, 32'h0);
    check("rst.valid",   {31'b0, insn_valid}, 32'h0);

    for (int k = 0; k <= 8; k++) run_vec(k);

    // First fetch after loading, with decode fields.
    fetch_once();
    check("f0.insn",    insn,    32'h2408_0005);
    check("f0.insn_pc", insn_pc, BASE);
    check("f0.pc",      pc,      BASE + 32'h04);
    check("f0.valid",   {31'b0, insn_valid}, 32'h1);
    check("f0.opcode",  {26'b0, opcode}, 32'h09);
    check("f0.rs",      {27'b0, rs},     32'h0);
    check("f0.rt",      {27'b0, rt},     32'h8);
    check("f0.rd",      {27'b0, rd},     32'h0);
    check("f0.shamt",   {27'b0, shamt},  32'h0);
    check("f0.funct",   {26'b0, funct},  32'h05);
    check("f0.imm",     {16'b0, imm},    32'h0005);

    for (int k = 9; k <= 15; k++) run_vec(k);

    // Asynchronous reset between clock edges while fetching at BASE+0x10.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.pc",    pc,    BASE);
    check("arst.valid", {31'b0, insn_valid}, 32'h0);
    check("arst.insn",  insn,  32'h0);
    do_reset();

    // Write strobe without loader mode must not touch memory; the edge fetches.
    drive(1'b0, 1'b1, 1'b0, 2'b11, BASE, 32'hFFFF_FFFF);
    step();
    check("nowr.insn", insn, 32'h2408_0005);
    check("nowr.pc",   pc,   BASE + 32'h04);
    do_reset();
    fetch_once();
    check("refetch.insn",    insn,    32'h2408_0005);
    check("refetch.insn_pc", insn_pc, BASE);

    // Walk pc to the end of memory, then fetch across the top.
    for (int n = 0; n < (DEPTH / 4) - 1; n++) fetch_once();
    check("end.pc", pc, BASE + 32'(DEPTH));
    fetch_once();
`ifdef MEM_BOUNDS_CHECK_EN
    wrap_exp = 32'h0000_0000;
`else
    wrap_exp = 32'h2408_0005;
`endif
    check("end.insn",    insn,    wrap_exp);
    check("end.insn_pc", insn_pc, BASE + 32'(DEPTH));
    check("end.pc_next", pc,      BASE + 32'(DEPTH) + 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
